if_stage: RTL and testbench

Instruction-fetch stage of the 8-bit pipelined core. It holds the PC, reads the instruction memory and drives the IF/ID pipeline register that feeds the decode stage (register read, 3-bit immediate sign-extension, jump-target formation). It accepts jump redirects and stalls from downstream. A small run-control FSM starts, halts and resumes fetch.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_imem.sv | 25 ++
 rtl/if_stage.sv | 104 ++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage of the 8-bit core.
// Field positions describe the instruction word format seen by decode.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fsm_state_t;

  localparam logic [7:0] NOP_INSTR  = 8'h00;
  localparam logic [7:0] HALT_INSTR = 8'hFF;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int REG_HI = 5;
  localparam int REG_LO = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  localparam logic [1:0] OP_JUMP = 2'b11;

  function automatic logic is_halt(input logic [7:0] word);
    return word == HALT_INSTR;
  endfunction

endpackage

// File: rtl/if_imem.sv
// Instruction memory: synchronous write port, combinational read port, no reset.
// A read of the address being written in the same cycle returns the old word.
module if_imem #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, run-control FSM and the IF/ID pipeline register.
// Jumps outrank stalls; latching the halt word parks the FSM until start.
module if_stage
  import if_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] instr_ifid,
  output logic [PC_W-1:0]    pc_ifid,
  output logic               valid_ifid,
  output logic               halted,
  output logic [PC_W-1:0]    pc_out
);

  localparam logic [INSTR_W-1:0] NopWord = INSTR_W'(NOP_INSTR);

  fsm_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcIfid_q, pcIfid_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] fetchWord;

  if_imem #(
    .AW(PC_W),
    .DW(INSTR_W)
  ) uImem (
    .clk_i  (clk),
    .we_i   (imem_we),
    .waddr_i(imem_waddr),
    .wdata_i(imem_wdata),
    .raddr_i(pc_q),
    .rdata_o(fetchWord)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= NopWord;
      pcIfid_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcIfid_q <= pcIfid_d;
      valid_q  <= valid_d;
    end
  end

  // Outside RUN the PC is frozen and IF/ID carries bubbles; pc_ifid keeps its last value.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcIfid_d = pcIfid_q;
    valid_d  = valid_q;
    unique case (state_q)
      RUN: begin
        if (jump_en) begin
          pc_d    = jump_target;
          instr_d = NopWord;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d  = fetchWord;
          pcIfid_d = pc_q + PC_W'(1);
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_W'(1);
          if (is_halt(fetchWord)) begin
            state_d = HALTED;
          end
        end
      end
      IDLE, HALTED: begin
        instr_d = NopWord;
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instr_ifid = instr_q;
  assign pc_ifid    = pcIfid_q;
  assign valid_ifid = valid_q;
  assign halted     = (state_q == HALTED);
  assign pc_out     = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences for
// reset and IDLE behaviour, then random traffic against a behavioural model.
module tb_if_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       imem_we = 1'b0;
  logic [7:0] imem_waddr = 8'h00;
  logic [7:0] imem_wdata = 8'h00;
  logic [7:0] instr_ifid;
  logic [7:0] pc_ifid;
  logic       valid_ifid;
  logic       halted;
  logic [7:0] pc_out;

  int assertions = 0;
  int failures = 0;

  if_stage #(.PC_W(8), .INSTR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_target(jump_target),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .instr_ifid (instr_ifid),
    .pc_ifid    (pc_ifid),
    .valid_ifid (valid_ifid),
    .halted     (halted),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stall;
    logic       jmp;
    logic [7:0] tgt;
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] eInstr;
    logic [7:0] ePcIfid;
    logic       eValid;
    logic       eHalted;
    logic [7:0] ePc;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: memory image plus the architectural view of IF/ID.
  logic [7:0] refMem[256];
  int         refMode;
  int         refPc;
  int         refPcIfid;
  logic [7:0] refInstr;
  bit         refValid;

  task automatic modelReset();
    refMode   = 0;
    refPc     = 0;
    refPcIfid = 0;
    refInstr  = 8'h00;
    refValid  = 0;
  endtask

  task automatic modelEdge();
    if (reset) begin
      if (refMode == 1) begin
        if (jump_en) begin
          refPc    = int'(jump_target);
          refInstr = 8'h00;
          refValid = 0;
        end else if (!stall) begin
          refInstr  = refMem[refPc];
          refPcIfid = (refPc + 1) % 256;
          refValid  = 1;
          refPc     = (refPc + 1) % 256;
          if (refInstr == 8'hFF) refMode = 2;
        end
      end else begin
        refInstr = 8'h00;
        refValid = 0;
        if (start) refMode = 1;
      end
    end
    if (imem_we) refMem[imem_waddr] = imem_wdata;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] eInstr, input logic [7:0] ePcIfid,
                          input logic eValid, input logic eHalted, input logic [7:0] ePc);
    checkOutput({tag, "_instr"}, 16'(instr_ifid), 16'(eInstr));
    checkOutput({tag, "_valid"}, 16'(valid_ifid), 16'(eValid));
    checkOutput({tag, "_halted"}, 16'(halted), 16'(eHalted));
    checkOutput({tag, "_pc"}, 16'(pc_out), 16'(ePc));
    if (eValid) checkOutput({tag, "_pc_ifid"}, 16'(pc_ifid), 16'(ePcIfid));
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [7:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic sl, input logic j, input logic [7:0] t,
                              input logic [7:0] eI, input logic [7:0] eP, input logic eV,
                              input logic eH, input logic [7:0] ePc);
    vec_t v;
    v.start = st; v.stall = sl; v.jmp = j; v.tgt = t;
    v.we = 1'b0; v.wa = 8'h00; v.wd = 8'h00;
    v.eInstr = eI; v.ePcIfid = eP; v.eValid = eV; v.eHalted = eH; v.ePc = ePc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    start       = v.start;
    stall       = v.stall;
    jump_en     = v.jmp;
    jump_target = v.tgt;
    imem_we     = v.we;
    imem_waddr  = v.wa;
    imem_wdata  = v.wd;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_instr"}, 16'(instr_ifid), 16'h00);
    checkOutput({tag, "_pc_ifid"}, 16'(pc_ifid), 16'h00);
    checkOutput({tag, "_valid"}, 16'(valid_ifid), 16'h0);
    checkOutput({tag, "_halted"}, 16'(halted), 16'h0);
    checkOutput({tag, "_pc"}, 16'(pc_out), 16'h00);
  endtask

  initial begin
    vec_t v;
    modelReset();
    #2;
    checkResetValues("por");

    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = 8'((i * 37 + 11) & 255);
      if (w == 8'hFF) w = 8'hFE;
      loadWord(8'(i), w);
    end
    loadWord(8'h00, 8'h41); loadWord(8'h01, 8'h52); loadWord(8'h02, 8'h63);
    loadWord(8'h03, 8'h74); loadWord(8'h04, 8'h85); loadWord(8'h05, 8'hFF);
    loadWord(8'h06, 8'h96); loadWord(8'h07, 8'hFF); loadWord(8'h08, 8'hC7);
    loadWord(8'h09, 8'h5A); loadWord(8'h3C, 8'hA5); loadWord(8'h3D, 8'hB6);
    loadWord(8'hFE, 8'h11); loadWord(8'hFF, 8'h22);
    checkResetValues("rst_held");

    reset = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkAll($sformatf("idle%0d", i), 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    end

    // start, successive fetch, stall, jumps, wrap, halt/resume, same-address write
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h41, 8'h01, 1, 0, 8'h01));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h52, 8'h02, 1, 0, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h52, 8'h02, 1, 0, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h52, 8'h02, 1, 0, 8'h02));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h63, 8'h03, 1, 0, 8'h03));
    vecs.push_back(mk(0, 0, 1, 8'h02, 8'h00, 8'h00, 0, 0, 8'h02));
    vecs.push_back(mk(0, 0, 1, 8'h3C, 8'h00, 8'h00, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hA5, 8'h3D, 1, 0, 8'h3D));
    vecs.push_back(mk(0, 1, 1, 8'h3C, 8'h00, 8'h00, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hA5, 8'h3D, 1, 0, 8'h3D));
    v = mk(0, 0, 1, 8'hFE, 8'h00, 8'h00, 0, 0, 8'hFE);
    v.we = 1'b1; v.wa = 8'h00; v.wd = 8'h33;
    vecs.push_back(v);
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h11, 8'hFF, 1, 0, 8'hFF));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h22, 8'h00, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h33, 8'h01, 1, 0, 8'h01));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h52, 8'h02, 1, 0, 8'h02));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h63, 8'h03, 1, 0, 8'h03));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h74, 8'h04, 1, 0, 8'h04));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h85, 8'h05, 1, 0, 8'h05));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFF, 8'h06, 1, 1, 8'h06));
    vecs.push_back(mk(0, 1, 1, 8'h40, 8'h00, 8'h00, 0, 1, 8'h06));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h06));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h06));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h06));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h96, 8'h07, 1, 0, 8'h07));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'hFF, 8'h08, 1, 1, 8'h08));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h08));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hC7, 8'h09, 1, 0, 8'h09));
    v = mk(0, 0, 0, 8'h00, 8'h5A, 8'h0A, 1, 0, 8'h0A);
    v.we = 1'b1; v.wa = 8'h09; v.wd = 8'hE1;
    vecs.push_back(v);
    vecs.push_back(mk(0, 0, 1, 8'h09, 8'h00, 8'h00, 0, 0, 8'h09));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'hE1, 8'h0A, 1, 0, 8'h0A));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].eInstr, vecs[i].ePcIfid,
               vecs[i].eValid, vecs[i].eHalted, vecs[i].ePc);
    end

    // Mid-run reset clears IF/ID immediately; IDLE ignores jump; IMEM survives.
    start = 1'b0; stall = 1'b0; jump_en = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    modelReset();
    checkResetValues("midrun_rst");
    reset = 1'b1;
    #1;
    jump_en = 1'b1; jump_target = 8'h55;
    tick();
    checkAll("idle_jump", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    jump_en = 1'b0; start = 1'b1;
    tick();
    checkAll("restart0", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    checkAll("restart1", 8'h33, 8'h01, 1'b1, 1'b0, 8'h01);

    // Random traffic against the reference model.
    start = 1'b0;
    reset = 1'b0;
    #2;
    modelReset();
    reset = 1'b1;
    #1;
    for (int c = 0; c < 400; c++) begin
      start       = ($urandom_range(0, 3) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      jump_en     = ($urandom_range(0, 9) == 0);
      jump_target = 8'($urandom);
      imem_we     = ($urandom_range(0, 4) == 0);
      imem_waddr  = ($urandom_range(0, 1) == 0) ? pc_out : 8'($urandom);
      imem_wdata  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      tick();
      checkAll($sformatf("rnd%0d", c), refInstr, 8'(refPcIfid), refValid,
               (refMode == 2), 8'(refPc));
    end
    imem_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
